// File: rtl/fifo_serial_tx.sv
// FIFO-fed UART-style transmitter: pops one 9-bit word per frame and sends start, 9 data bits LSB first, stop bit(s).
// Optional even-parity bit after the data bits when FIFO_SERIAL_TX_PARITY_EN is defined.
module fifo_serial_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int STOP_BITS    = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fin,
    input  logic [8:0]  fdata,
    output logic        fstall,
    output logic        txd,
    output logic        tx_busy,
    output logic [15:0] frame_cnt
);

`ifdef FIFO_SERIAL_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    localparam logic [7:0] CNT_LAST  = 8'(CLKS_PER_BIT - 1);
    localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

    state_t      state_q, state_d;
    logic [7:0]  clk_cnt_q, clk_cnt_d;
    logic [3:0]  bit_idx_q, bit_idx_d;
    logic        stop_idx_q, stop_idx_d;
    logic [8:0]  shift_q, shift_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
`ifdef FIFO_SERIAL_TX_PARITY_EN
    logic        parity_q, parity_d;
`endif

    logic bit_last;
    logic frame_end;
    logic pop;

    assign bit_last  = (clk_cnt_q == CNT_LAST);
    assign frame_end = (state_q == S_STOP) && bit_last && (stop_idx_q == STOP_LAST);
    assign pop       = fin & ~fstall;
    assign frame_cnt = frame_cnt_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            clk_cnt_q   <= '0;
            bit_idx_q   <= '0;
            stop_idx_q  <= 1'b0;
            shift_q     <= '0;
            frame_cnt_q <= '0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_idx_q   <= bit_idx_d;
            stop_idx_q  <= stop_idx_d;
            shift_q     <= shift_d;
            frame_cnt_q <= frame_cnt_d;
`ifdef FIFO_SERIAL_TX_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = bit_last ? 8'd0 : clk_cnt_q + 8'd1;
        bit_idx_d   = bit_idx_q;
        stop_idx_d  = stop_idx_q;
        shift_d     = shift_q;
        frame_cnt_d = frame_cnt_q;
`ifdef FIFO_SERIAL_TX_PARITY_EN
        parity_d    = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                clk_cnt_d = 8'd0;
            end
            S_START: begin
                if (bit_last) begin
                    state_d   = S_DATA;
                    bit_idx_d = 4'd0;
                end
            end
            S_DATA: begin
                if (bit_last) begin
                    if (bit_idx_q == 4'd8) begin
`ifdef FIFO_SERIAL_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                        stop_idx_d = 1'b0;
                    end else begin
                        shift_d   = {1'b0, shift_q[8:1]};
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end
`ifdef FIFO_SERIAL_TX_PARITY_EN
            S_PARITY: begin
                if (bit_last) begin
                    state_d    = S_STOP;
                    stop_idx_d = 1'b0;
                end
            end
`endif
            S_STOP: begin
                if (bit_last) begin
                    if (stop_idx_q == STOP_LAST) begin
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        state_d     = S_IDLE;
                    end else begin
                        stop_idx_d = stop_idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // A pop overrides the idle/stop exit so back-to-back frames need no idle cycle.
        if (pop) begin
            state_d   = S_START;
            shift_d   = fdata;
            clk_cnt_d = 8'd0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
            parity_d  = ^fdata;
`endif
        end
    end

    always_comb begin
        txd     = 1'b1;
        tx_busy = 1'b1;
        fstall  = ~reset | ~((state_q == S_IDLE) | frame_end);
        case (state_q)
            S_IDLE:   tx_busy = 1'b0;
            S_START:  txd = 1'b0;
            S_DATA:   txd = shift_q[0];
`ifdef FIFO_SERIAL_TX_PARITY_EN
            S_PARITY: txd = parity_q;
`endif
            S_STOP:   txd = 1'b1;
            default: begin
                txd     = 1'b1;
                tx_busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Bench for fifo_serial_tx: the bench plays the FIFO and predicts the line waveform from a per-cycle bit queue.
module tb_fifo_serial_tx;
    localparam int CPB = 4;
    localparam int SB  = 1;
`ifdef FIFO_SERIAL_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FL  = (10 + SB + PB) * CPB;
    localparam int FL2 = (10 + 2 + PB) * 2;

    logic        clock;
    logic        reset;
    logic        fin, fin2;
    logic [8:0]  fdata, fdata2;
    logic        fstall, fstall2;
    logic        txd, txd2;
    logic        tx_busy, tx_busy2;
    logic [15:0] frame_cnt, frame_cnt2;

    fifo_serial_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(SB)) dut (
        .clock(clock), .reset(reset), .fin(fin), .fdata(fdata),
        .fstall(fstall), .txd(txd), .tx_busy(tx_busy), .frame_cnt(frame_cnt)
    );

    fifo_serial_tx #(.CLKS_PER_BIT(2), .STOP_BITS(2)) dut2 (
        .clock(clock), .reset(reset), .fin(fin2), .fdata(fdata2),
        .fstall(fstall2), .txd(txd2), .tx_busy(tx_busy2), .frame_cnt(frame_cnt2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          total = 0;
    int          bad = 0;
    logic [8:0]  fifo_q[$];
    bit          exp_line[$];
    bit          cap[$];
    logic [15:0] exp_cnt;

    typedef struct {
        logic [8:0] data;
        int         ones;
        logic       par;
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Whole-frame waveform in line order, each bit held cpb cycles.
    task automatic add_frame(input logic [8:0] w, input int cpb, input int sb);
        bit seq[$];
        seq.push_back(1'b0);
        for (int i = 0; i < 9; i++) seq.push_back(w[i]);
`ifdef FIFO_SERIAL_TX_PARITY_EN
        seq.push_back(^w);
`endif
        for (int i = 0; i < sb; i++) seq.push_back(1'b1);
        foreach (seq[k])
            for (int j = 0; j < cpb; j++) exp_line.push_back(seq[k]);
    endtask

    task automatic step();
        bit idle;
        bit exp_fstall;
        idle       = (exp_line.size() == 0);
        exp_fstall = !(idle || exp_line.size() == 1);
        chk("txd", txd, idle ? 1'b1 : exp_line[0]);
        chk("tx_busy", tx_busy, !idle);
        chk("fstall", fstall, exp_fstall);
        chk("frame_cnt", frame_cnt, exp_cnt);
        if (tx_busy) cap.push_back(txd);
        fin   = (fifo_q.size() > 0);
        fdata = fin ? fifo_q[0] : 9'($urandom);
        if (!idle) begin
            if (exp_line.size() == 1) exp_cnt++;
            void'(exp_line.pop_front());
        end
        if (fin && !exp_fstall) add_frame(fifo_q.pop_front(), CPB, SB);
    endtask

    task automatic tick();
        @(negedge clock);
        step();
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while ((exp_line.size() > 0 || fifo_q.size() > 0) && n < limit);
        chk("drain_timeout", (n < limit), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int          ones;
        int          n;
        logic [15:0] c0;

        vecs[0] = '{9'h1A5, 5, 1'b1};
        vecs[1] = '{9'h000, 0, 1'b0};
        vecs[2] = '{9'h1FF, 9, 1'b1};
        vecs[3] = '{9'h0F0, 4, 1'b0};
        vecs[4] = '{9'h103, 3, 1'b1};
        vecs[5] = '{9'h003, 2, 1'b0};
        vecs[6] = '{9'h100, 1, 1'b1};
        vecs[7] = '{9'h0AA, 4, 1'b0};

        reset  = 1'b0;
        fin    = 1'b1;
        fdata  = 9'h1A5;
        fin2   = 1'b0;
        fdata2 = 9'h000;
        exp_cnt = 16'd0;
        repeat (3) @(negedge clock);
        chk("rst_fstall", fstall, 1);
        chk("rst_txd", txd, 1);
        chk("rst_busy", tx_busy, 0);
        chk("rst_cnt", frame_cnt, 0);
        reset = 1'b1;
        #1;
        step();

        // Single-word frames from the table; data-bit ones and parity sampled mid-bit.
        for (int v = 0; v < 8; v++) begin
            cap.delete();
            fifo_q.push_back(vecs[v].data);
            drain(200);
            chk("vec_len", cap.size(), FL);
            ones = 0;
            if (cap.size() == FL) begin
                for (int i = 0; i < 9; i++) ones += int'(cap[(1 + i) * CPB + CPB / 2]);
`ifdef FIFO_SERIAL_TX_PARITY_EN
                chk("vec_par", cap[10 * CPB + CPB / 2], vecs[v].par);
`endif
            end
            chk("vec_ones", ones, vecs[v].ones);
        end
        tick();
        chk("vec_frames", frame_cnt, 8);

        // Reset asserted mid-frame with fin high.
        fifo_q.push_back(9'h0F0);
        repeat (15) tick();
        @(negedge clock);
        reset = 1'b0;
        fin   = 1'b1;
        fdata = 9'h155;
        #1;
        chk("mid_rst_fstall", fstall, 1);
        chk("mid_rst_txd", txd, 1);
        chk("mid_rst_busy", tx_busy, 0);
        chk("mid_rst_cnt", frame_cnt, 0);
        repeat (3) begin
            @(negedge clock);
            chk("hold_rst_fstall", fstall, 1);
            chk("hold_rst_busy", tx_busy, 0);
        end
        exp_line.delete();
        fifo_q.delete();
        fifo_q.push_back(9'h155);
        exp_cnt = 16'd0;
        reset = 1'b1;
        #1;
        step();
        drain(200);

        // Three words back to back.
        tick();
        cap.delete();
        c0 = exp_cnt;
        fifo_q.push_back(9'h000);
        fifo_q.push_back(9'h1FF);
        fifo_q.push_back(9'h0F0);
        drain(400);
        chk("b2b_len", cap.size(), 3 * FL);
        tick();
        chk("b2b_frames", frame_cnt, c0 + 16'd3);

        // Idle gap, then a late word.
        repeat (6) tick();
        fifo_q.push_back(9'h0C3);
        drain(200);

        // Random arrivals.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0 && fifo_q.size() < 4)
                fifo_q.push_back(9'($urandom_range(0, 511)));
            tick();
        end
        drain(1000);

        // Two stop bits, two clocks per bit, counter wrap.
        @(negedge clock);
        force dut2.frame_cnt_q = 16'hFFFF;
        @(negedge clock);
        release dut2.frame_cnt_q;
        chk("wrap_preload", frame_cnt2, 16'hFFFF);
        fin2   = 1'b1;
        fdata2 = 9'h055;
        @(negedge clock);
        fin2   = 1'b0;
        fdata2 = 9'h1AA;
        cap.delete();
        n = 0;
        while (tx_busy2 && n < 100) begin
            cap.push_back(txd2);
            n++;
            @(negedge clock);
        end
        chk("sb2_len", n, FL2);
        if (cap.size() >= 5) begin
            chk("sb2_start", cap[0], 0);
            chk("sb2_stop_a", cap[cap.size() - 4], 1);
            chk("sb2_stop_d", cap[cap.size() - 1], 1);
            chk("sb2_lastdata", cap[cap.size() - 5 - 2 * PB], 0);
        end
        chk("sb2_wrap", frame_cnt2, 16'h0000);
        chk("sb2_idle_fstall", fstall2, 0);
        chk("sb2_idle_txd", txd2, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fifo_serial_tx.md
Name: fifo_serial_tx

Overview:
- Consumer/transmitter for the 9-bit FIFO read-side interface: fifo valid (`fin`), fifo data (`fdata`), stall back to FIFO (`fstall`).
- Pops one word at a time and serializes it onto a single UART-style line: start bit, 9 data bits LSB first, optional parity, stop bit(s).
- Sits directly downstream of the FIFO; `fstall` connects to the FIFO stall input, `fin`/`fdata` to its valid/data outputs.

Parameters:
- CLKS_PER_BIT, 4, clock cycles per serial bit; legal range 2..255.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; asserted when 0.
- fin  input  1  FIFO non-empty / data valid.
- fdata  input  9  FIFO head word; valid whenever fin=1.
- fstall  output  1  stall to FIFO; a pop occurs on any rising edge with fin=1 and fstall=0.
- txd  output  1  serial line; idles high.
- tx_busy  output  1  high while a frame is on the line.
- frame_cnt  output  16  count of frames fully sent (stop bit(s) completed).

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, txd=1, tx_busy=0, frame_cnt=0.
  - fstall=1 while reset is asserted.
  - An in-flight word is discarded; it was already popped and is not re-read.
- States: IDLE, START, DATA, PARITY (PARITY_EN only), STOP.
  - Registers: bit-period counter clk_cnt (0..CLKS_PER_BIT-1), bit index bit_idx (0..8), stop index, 9-bit shift register.
- Output decoding:
  - txd and tx_busy are decoded from registered state only; no combinational path from fin/fdata to txd.
  - fstall=0 only in IDLE, or in the final clk_cnt cycle of the final stop bit. fstall=1 otherwise, including during reset.
- Pop/load:
  - On a rising edge with fin=1 and fstall=0, capture fdata into the shift register, clear clk_cnt, and go to START.
  - Only one word is popped per frame. fdata is never sampled outside a pop edge.
- START: txd=0 for CLKS_PER_BIT cycles, then DATA with bit_idx=0.
- DATA:
  - txd=shift[0]. Every CLKS_PER_BIT cycles, shift right and increment bit_idx.
  - After bit_idx=8 completes, go to PARITY if enabled, else STOP.
- STOP:
  - txd=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - On the last cycle, frame_cnt increments; it wraps 0xFFFF->0x0000.
  - If fin=1 at that edge, load the next word and go directly to START (back-to-back, zero idle cycles). Otherwise go to IDLE.
- tx_busy=1 in START, DATA, PARITY and STOP; 0 in IDLE.
- Frame length: (10 + STOP_BITS [+1 with parity]) * CLKS_PER_BIT cycles.
  - Defaults: 11 bits = 44 cycles per frame.
- fin dropping while busy has no effect; fin is only evaluated on edges where fstall=0.

Optional Feature:
- Macro: FIFO_SERIAL_TX_PARITY_EN.
- Defined:
  - PARITY state inserted after DATA; txd = XOR of the 9 captured data bits (even parity) for CLKS_PER_BIT cycles.
  - Default frame becomes 12 bits = 48 cycles.
- Undefined: no PARITY state or logic; DATA goes directly to STOP.

Test Plan:
1. Reset with fin=1, then hold reset=0 mid-frame -> fstall=1, txd=1, tx_busy=0, frame_cnt=0 immediately; no pop edge while reset is asserted.
2. Defaults, single word 9'h1A5, fin high for one pop edge only -> exactly one pop. txd = 0, then 1,0,1,0,0,1,0,1,1 (LSB first), then 1, each held 4 cycles. tx_busy high for 44 cycles; frame_cnt=1.
3. Three words 9'h000, 9'h1FF, 9'h0F0 with fin held high -> pops only at the load edge and the last-STOP-cycle edges; frames back-to-back with no idle cycle. 132 cycles total; frame_cnt=3.
4. FIFO empty (fin=0) after a frame -> IDLE with fstall=0 and txd=1. fin rising later -> START begins the cycle after the pop edge.
5. PARITY_EN defined, word 9'h103 (3 ones) -> parity bit 1. Word 9'h003 -> parity bit 0. Frame 48 cycles.
6. STOP_BITS=2, CLKS_PER_BIT=2, preload frame_cnt to 16'hFFFF via force -> stop high for 4 cycles; frame_cnt wraps to 16'h0000 after the frame.
